// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//
// Parameterised pipeline register chain with a per-stage valid bit, used to
// carry instruction results between pipeline stages.  DEPTH cascaded stages
// all update on the falling edge of clk.  Each edge applies exactly one of
// the following actions, listed from highest to lowest priority:
//   reset   - empty the pipe
//   flush   - empty the pipe
//   stall   - hold every stage and drop the incoming word
//   advance - shift one stage towards the output
// Every empty slot (bubble) carries RESET_VAL, so out_data is deterministic
// even when out_valid is low.
//
// Parameters
//   WIDTH     data width in bits (1..64)
//   DEPTH     number of cascaded stages (1..7)
//   RESET_VAL data value of every stage after reset or flush
//
// Ports
//   clk        in   single clock; all state changes on its falling edge
//   reset      in   synchronous active-high reset
//   in_data    in   [WIDTH-1:0] data entering stage 0
//   in_valid   in   in_data carries a real result
//   stall      in   freeze all stages; the incoming word is dropped
//   flush      in   turn every stage into a bubble
//   out_data   out  [WIDTH-1:0] last stage data (direct flop output)
//   out_valid  out  last stage valid bit (direct flop output)
//   occ        out  [2:0] number of stages holding valid data (flop output)
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             stall,
  input  logic             flush,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic [2:0]       occ
);

  logic [WIDTH-1:0] data_r [DEPTH];
  logic [DEPTH-1:0] valid_r;
  logic [2:0]       occ_r;

  logic [WIDTH-1:0] stage0_data_s;
  logic             stage0_valid_s;
  logic [2:0]       occ_adv_s;

  // Next stage-0 contents and the occupancy an advance would produce
  always_comb begin
    stage0_data_s  = RESET_VAL;
    stage0_valid_s = 1'b0;
    if (in_valid) begin
      stage0_data_s  = in_data;
      stage0_valid_s = 1'b1;
    end else begin
      stage0_data_s  = RESET_VAL;
      stage0_valid_s = 1'b0;
    end
    // One word may enter and one may leave on each advance.  The count is
    // bounded by DEPTH (at most 7), so it always fits in 3 bits.
    occ_adv_s = occ_r + {2'b00, in_valid} - {2'b00, valid_r[DEPTH-1]};
  end

  // Stage registers, valid bits and occupancy counter
  always_ff @(negedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        data_r[k] <= RESET_VAL;
      end
      valid_r <= {DEPTH{1'b0}};
      occ_r   <= 3'd0;
    end else if (flush) begin
      for (int k = 0; k < DEPTH; k++) begin
        data_r[k] <= RESET_VAL;
      end
      valid_r <= {DEPTH{1'b0}};
      occ_r   <= 3'd0;
    end else if (!stall) begin
      data_r[0]  <= stage0_data_s;
      valid_r[0] <= stage0_valid_s;
      for (int k = 1; k < DEPTH; k++) begin
        data_r[k]  <= data_r[k-1];
        valid_r[k] <= valid_r[k-1];
      end
      occ_r <= occ_adv_s;
    end else begin
      // Stalled: every stage keeps its contents and the incoming word is lost.
      occ_r <= occ_r;
    end
  end

  assign out_data  = data_r[DEPTH-1];
  assign out_valid = valid_r[DEPTH-1];
  assign occ       = occ_r;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Self-checking bench for pipe_stage_reg.  Three instances share one set of
// inputs:
//   u_d2  WIDTH=32  DEPTH=2  RESET_VAL=0
//   u_d1  WIDTH=32  DEPTH=1  RESET_VAL=FFFFFFFF
//   u_d7  WIDTH=32  DEPTH=7  RESET_VAL=FFFFFFFF
// The reference model treats each pipe as a FIFO of fixed length holding
// {valid,data} entries.  On each edge a new entry goes in at the front and
// the oldest entry falls out of the back.  occ is the number of valid
// entries in the FIFO.
// ---------------------------------------------------------------------------
module tb_pipe_stage_reg;

  typedef logic [32:0] ent_t;
  typedef ent_t        eq_t[$];

  logic        clk;
  logic        reset;
  logic [31:0] in_data;
  logic        in_valid;
  logic        stall;
  logic        flush;

  logic [31:0] d2_data, d1_data, d7_data;
  logic        d2_valid, d1_valid, d7_valid;
  logic [2:0]  d2_occ, d1_occ, d7_occ;

  int n_cmp;
  int n_err;

  eq_t q2, q1, q7;

  pipe_stage_reg #(.WIDTH(32), .DEPTH(2), .RESET_VAL(32'h0000_0000)) u_d2 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .stall(stall), .flush(flush),
    .out_data(d2_data), .out_valid(d2_valid), .occ(d2_occ));

  pipe_stage_reg #(.WIDTH(32), .DEPTH(1), .RESET_VAL(32'hFFFF_FFFF)) u_d1 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .stall(stall), .flush(flush),
    .out_data(d1_data), .out_valid(d1_valid), .occ(d1_occ));

  pipe_stage_reg #(.WIDTH(32), .DEPTH(7), .RESET_VAL(32'hFFFF_FFFF)) u_d7 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .stall(stall), .flush(flush),
    .out_data(d7_data), .out_valid(d7_valid), .occ(d7_occ));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: apply one edge to a FIFO of fixed length
  function automatic eq_t mstep(eq_t q, int depth, logic [31:0] rv,
                                logic rst, logic fl, logic st,
                                logic iv, logic [31:0] id);
    eq_t r;
    r = q;
    if (rst || fl) begin
      r = {};
      for (int i = 0; i < depth; i++) r.push_back({1'b0, rv});
    end else if (!st) begin
      r.push_front(iv ? {1'b1, id} : {1'b0, rv});
      void'(r.pop_back());
    end
    return r;
  endfunction

  function automatic int mocc(eq_t q);
    int c;
    c = 0;
    foreach (q[i]) if (q[i][32]) c++;
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_inst(input string tag, input eq_t q,
                          input logic [31:0] od, input logic ov, input logic [2:0] oc);
    ent_t last;
    last = q[q.size()-1];
    chk({tag, ".data"},  od, last[31:0]);
    chk({tag, ".valid"}, {31'd0, ov}, {31'd0, last[32]});
    chk({tag, ".occ"},   {29'd0, oc}, mocc(q));
  endtask

  // Drive one edge's inputs, let the falling edge happen, then check all instances
  task automatic step(input logic rst, input logic fl, input logic st,
                      input logic iv, input logic [31:0] id);
    reset    = rst;
    flush    = fl;
    stall    = st;
    in_valid = iv;
    in_data  = id;
    @(negedge clk);
    #1;
    q2 = mstep(q2, 2, 32'h0000_0000, rst, fl, st, iv, id);
    q1 = mstep(q1, 1, 32'hFFFF_FFFF, rst, fl, st, iv, id);
    q7 = mstep(q7, 7, 32'hFFFF_FFFF, rst, fl, st, iv, id);
    chk_inst("d2", q2, d2_data, d2_valid, d2_occ);
    chk_inst("d1", q1, d1_data, d1_valid, d1_occ);
    chk_inst("d7", q7, d7_data, d7_valid, d7_occ);
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    reset    = 1'b1;
    flush    = 1'b0;
    stall    = 1'b0;
    in_valid = 1'b0;
    in_data  = 32'h0;
    @(posedge clk);

    // Initial reset
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("init.d2_data", d2_data, 32'h0000_0000);
    chk("init.d7_data", d7_data, 32'hFFFF_FFFF);
    chk("init.d2_occ", {29'd0, d2_occ}, 32'd0);

    // Reset with the pipe full of DEADBEEF
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    chk("full.d2_data", d2_data, 32'hDEAD_BEEF);
    chk("full.d2_occ", {29'd0, d2_occ}, 32'd2);
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    chk("rst.d2_data", d2_data, 32'h0000_0000);
    chk("rst.d2_valid", {31'd0, d2_valid}, 32'd0);
    chk("rst.d2_occ", {29'd0, d2_occ}, 32'd0);

    // Latency of DEPTH=2
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0011);
    chk("lat1.d2_valid", {31'd0, d2_valid}, 32'd0);
    chk("lat1.d2_occ", {29'd0, d2_occ}, 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0022);
    chk("lat2.d2_data", d2_data, 32'h0000_0011);
    chk("lat2.d2_occ", {29'd0, d2_occ}, 32'd2);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0099);
    chk("lat3.d2_data", d2_data, 32'h0000_0022);
    chk("lat3.d2_occ", {29'd0, d2_occ}, 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0099);
    chk("lat4.d2_data", d2_data, 32'h0000_0000);
    chk("lat4.d2_valid", {31'd0, d2_valid}, 32'd0);
    chk("lat4.d2_occ", {29'd0, d2_occ}, 32'd0);

    // Stall freezes the pipe and drops the incoming word
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_000A);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_000B);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_000C);
      chk("stall.d2_data", d2_data, 32'h0000_000A);
      chk("stall.d2_occ", {29'd0, d2_occ}, 32'd2);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000);
    chk("unstall.d2_data", d2_data, 32'h0000_000B);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000);
    chk("unstall2.d2_valid", {31'd0, d2_valid}, 32'd0);
    chk("unstall2.d2_data", d2_data, 32'h0000_0000);

    // Flush wins over stall and drops the incoming word
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0031);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0032);
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0077);
    chk("flush.d2_valid", {31'd0, d2_valid}, 32'd0);
    chk("flush.d2_data", d2_data, 32'h0000_0000);
    chk("flush.d2_occ", {29'd0, d2_occ}, 32'd0);
    chk("flush.d7_occ", {29'd0, d7_occ}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000);
    chk("flush2.d2_occ", {29'd0, d2_occ}, 32'd0);

    // Reset wins over stall and in_valid
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0041);
    step(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0005);
    chk("rprio.d2_occ", {29'd0, d2_occ}, 32'd0);
    chk("rprio.d1_valid", {31'd0, d1_valid}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0005);
    chk("rprio2.d2_occ", {29'd0, d2_occ}, 32'd1);
    chk("rprio2.d2_valid", {31'd0, d2_valid}, 32'd0);
    chk("rprio2.d1_data", d1_data, 32'h0000_0005);

    // Latency of DEPTH=1 and DEPTH=7; their bubbles read all ones
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_1234);
    chk("d1lat.data", d1_data, 32'h0000_1234);
    for (int e = 2; e <= 7; e++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("d1bub.data", d1_data, 32'hFFFF_FFFF);
      chk("d7lat.valid", {31'd0, d7_valid}, (e == 7) ? 32'd1 : 32'd0);
    end
    chk("d7lat.data", d7_data, 32'h0000_1234);
    for (int e = 0; e < 7; e++) step(1'b0, 1'b0, 1'b0, 1'b1, 32'h100 + e);
    chk("d7max.occ", {29'd0, d7_occ}, 32'd7);
    chk("d1max.occ", {29'd0, d1_occ}, 32'd1);
    chk("d7max.data", d7_data, 32'h0000_0100);

    // Randomised traffic checked against the model
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0,
           $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
